// File: rtl/pwm_pkg.sv
// Shared PWM width, duty type and period length for the pwm_gen block.
package pwm_pkg;

    localparam int PWM_WIDTH  = 11;
    typedef logic [PWM_WIDTH-1:0] pwm_duty_t;
    localparam int PWM_PERIOD = 2**PWM_WIDTH;

endpackage

// File: rtl/pwm_counter.sv
// Free-running WIDTH-bit period counter; o_wrap flags the last count of the period.
module pwm_counter #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_wrap
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            // Natural overflow wraps all-ones back to zero with no idle cycle.
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_wrap = &r_cnt;

endmodule

// File: rtl/pwm_gen.sv
// Fixed-period PWM: output registered high for duty+1 clocks of every 2^WIDTH-clock period.
// Define PWM_SYNC_UPDATE_EN to latch duty only at period boundaries (glitch-free updates).
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] duty,
    output logic             PWM_sig
);

    logic [WIDTH-1:0] w_cnt;
    logic             w_wrap;
    logic [WIDTH-1:0] w_duty_eff;

    pwm_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_cnt  (w_cnt),
        .o_wrap (w_wrap)
    );

`ifdef PWM_SYNC_UPDATE_EN
    logic             r_period_start;
    logic [WIDTH-1:0] r_duty_q;

    // r_period_start mirrors cnt==0: set out of reset, then follows the wrap flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period_start <= 1'b1;
            r_duty_q       <= '0;
        end else begin
            r_period_start <= w_wrap;
            if (r_period_start) begin
                r_duty_q <= duty;
            end
        end
    end

    assign w_duty_eff = r_period_start ? duty : r_duty_q;
`else
    logic w_unused_wrap;

    assign w_unused_wrap = w_wrap;
    assign w_duty_eff    = duty;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PWM_sig <= 1'b0;
        end else begin
            PWM_sig <= (w_cnt <= w_duty_eff);
        end
    end

endmodule

// File: tb/tb_pwm_gen.sv
// Scoreboard bench for pwm_gen: expected per-edge output levels queued by stimulus, checked by a monitor.
module tb_pwm_gen;
    import pwm_pkg::*;

    logic      clk;
    logic      rst_n;
    pwm_duty_t duty;
    logic      PWM_sig;

    int n_checks = 0;
    int n_errors = 0;
    int edge_idx = 0;

    logic exp_q[$];

    pwm_gen #(
        .WIDTH (PWM_WIDTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .duty    (duty),
        .PWM_sig (PWM_sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: PWM_sig=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: output is presented every clock, so one queued level is consumed per negedge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic e;
            e = exp_q.pop_front();
            edge_idx++;
            check($sformatf("pwm_edge%0d", edge_idx), PWM_sig, e);
        end
    end

    // Expect the next n clock edges to leave PWM_sig at level v.
    task automatic expect_run(input int n, input logic v);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            exp_q.push_back(v);
        end
    endtask

    // Asynchronous reset between edges, load a new duty, release at a negedge.
    task automatic do_reset(input pwm_duty_t d, input string name);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check({name, "_async_clear"}, PWM_sig, 1'b0);
        duty = d;
        @(posedge clk);
        @(posedge clk);
        #1;
        check({name, "_held_in_reset"}, PWM_sig, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        edge_idx = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        duty  = '0;
        #1;
        check("reset_state", PWM_sig, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_state_clocked", PWM_sig, 1'b0);

        // duty=0: one clock high, 2047 low, high again on edge 2049.
        @(negedge clk);
        rst_n = 1'b1;
        expect_run(1, 1'b1);
        expect_run(2047, 1'b0);
        expect_run(1, 1'b1);
        expect_run(100, 1'b0);

        // Mid-period async reset, then duty=0x7FF: high on all edges across the wrap.
        do_reset(11'h7FF, "mid_period");
        expect_run(2049, 1'b1);

        // PWM_sig is high here: reset between edges must clear it without a clock.
        do_reset(11'h0FF, "clear_while_high");
        expect_run(256, 1'b1);
        expect_run(1792, 1'b0);
        expect_run(1, 1'b1);

        // Mid-period duty change 0x0FF -> 0x3FF once cnt has passed 0x100.
        do_reset(11'h0FF, "duty_change");
        expect_run(256, 1'b1);
        expect_run(1, 1'b0);
        #1;
        duty = 11'h3FF;
`ifdef PWM_SYNC_UPDATE_EN
        expect_run(1791, 1'b0);
`else
        expect_run(767, 1'b1);
        expect_run(1024, 1'b0);
`endif
        expect_run(1024, 1'b1);
        expect_run(1, 1'b0);

        // duty=0x400 for two periods: 1025 high / 1023 low each.
        do_reset(11'h400, "half_duty");
        for (int p = 0; p < 2; p++) begin
            expect_run(1025, 1'b1);
            expect_run(1023, 1'b0);
        end
        expect_run(1, 1'b1);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 2000000");
        $fatal(1, "watchdog expired");
    end

endmodule
